// File: rtl/rf_2p_pkg.sv
// Shared constants for controllers driving the 1024x8 two-port register file macro.
package rf_2p_pkg;

    localparam int unsigned RF_AW    = 10;
    localparam int unsigned RF_DW    = 8;
    localparam int unsigned RF_DEPTH = 1024;

    localparam logic [2:0] RF_EMA_DEFAULT = 3'b010;

endpackage : rf_2p_pkg

// File: rtl/rf_2p_fifo_outbuf.sv
// Two-entry output buffer (out + skid) that absorbs the macro's one-cycle read
// latency so the read stream can stay show-ahead under arbitrary backpressure.
module rf_2p_fifo_outbuf
    import rf_2p_pkg::*;
#(
    parameter int unsigned DW = RF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          pop,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);

    logic          out_v_q;
    logic          out_v_d;
    logic [DW-1:0] out_d_q;
    logic [DW-1:0] out_d_d;
    logic          skid_v_q;
    logic          skid_v_d;
    logic [DW-1:0] skid_d_q;
    logic [DW-1:0] skid_d_d;

    // Next-state: pop promotes skid into out, then returning data fills the first free slot.
    always_comb begin
        out_v_d  = out_v_q;
        out_d_d  = out_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            if (pop) begin
                out_v_d  = skid_v_q;
                out_d_d  = skid_d_q;
                skid_v_d = 1'b0;
            end
            if (in_valid) begin
                if (!out_v_d) begin
                    out_v_d = 1'b1;
                    out_d_d = in_data;
                end else begin
                    skid_v_d = 1'b1;
                    skid_d_d = in_data;
                end
            end
        end
    end

    // Buffer registers; out data resets to zero so rd_data is defined during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q  <= 1'b0;
            out_d_q  <= '0;
            skid_v_q <= 1'b0;
            skid_d_q <= '0;
        end else begin
            out_v_q  <= out_v_d;
            out_d_q  <= out_d_d;
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
        end
    end

    // Status outputs seen by the read port and the issue logic.
    always_comb begin
        out_valid = out_v_q;
        out_data  = out_d_q;
        occ       = {1'b0, out_v_q} + {1'b0, skid_v_q};
    end

endmodule : rf_2p_fifo_outbuf

// File: rtl/rf_2p_fifo_ctrl.sv
// Show-ahead FIFO controller for the two-port register file macro: port A reads,
// port B writes, and a 2-entry output buffer hides the one-cycle read latency.
module rf_2p_fifo_ctrl
    import rf_2p_pkg::*;
#(
    parameter int unsigned AW    = RF_AW,
    parameter int unsigned DW    = RF_DW,
    parameter logic [2:0]  EMA_A = RF_EMA_DEFAULT,
    parameter logic [2:0]  EMA_B = RF_EMA_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          rf_cena,
    output logic [AW-1:0] rf_aa,
    input  logic [DW-1:0] rf_qa,
    output logic          rf_cenb,
    output logic [AW-1:0] rf_ab,
    output logic [DW-1:0] rf_db,
    output logic [2:0]    rf_emaa,
    output logic [2:0]    rf_emab,
    output logic          rf_ret1n,
    output logic          rf_colldisn
);

    localparam int unsigned CW    = AW + 1;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic          init_done_q;
    logic          init_done_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   ram_cnt_q;
    logic [AW:0]   ram_cnt_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          inflight_q;
    logic          inflight_d;

    logic          push;
    logic          pop;
    logic          issue;
    logic [1:0]    buf_occ;
    logic          ob_valid;
    logic [DW-1:0] ob_data;
    logic [1:0]    ob_occ;

    // Handshake and issue decode; wr_ready depends only on registered state and flush.
    always_comb begin
        wr_ready = init_done_q && !flush && (ram_cnt_q < DEPTH);
        push     = wr_valid && wr_ready;
        pop      = ob_valid && rd_ready && !flush;
        buf_occ  = {1'b0, inflight_q} + ob_occ;
        // A full buffer may still issue when a pop frees the slot the returning word will need.
        issue    = !flush && (ram_cnt_q != '0) &&
                   ((buf_occ < 2'd2) || ((buf_occ == 2'd2) && pop));
    end

    // Pointer and counter next-state; flush overrides every other update.
    always_comb begin
        init_done_d = 1'b1;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        count_d     = count_q;
        inflight_d  = 1'b0;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            count_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(issue);
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = issue;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
        end else begin
            init_done_q <= init_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
        end
    end

    rf_2p_fifo_outbuf #(
        .DW (DW)
    ) u_outbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (inflight_q && !flush),
        .in_data   (rf_qa),
        .pop       (pop),
        .out_valid (ob_valid),
        .out_data  (ob_data),
        .occ       (ob_occ)
    );

    // Macro pins and stream outputs; static macro controls are tied off here.
    always_comb begin
        rf_cena     = !issue;
        rf_aa       = rd_ptr_q;
        rf_cenb     = !push;
        rf_ab       = wr_ptr_q;
        rf_db       = wr_data;
        rf_emaa     = EMA_A;
        rf_emab     = EMA_B;
        rf_ret1n    = 1'b1;
        rf_colldisn = 1'b1;
        rd_valid    = ob_valid;
        rd_data     = ob_data;
        count       = count_q;
    end

endmodule : rf_2p_fifo_ctrl

// File: tb/tb_rf_2p_fifo_ctrl.sv
// Bench for rf_2p_fifo_ctrl: macro model plus a queue-based FIFO model with
// per-entry acceptance time, compared against the DUT every cycle.
module tb_rf_2p_fifo_ctrl;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned CAP   = 1026;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_valid = 1'b1;
    logic        wr_ready;
    logic [7:0]  wr_data = 8'h11;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [7:0]  rd_data;
    logic [10:0] count;
    logic        rf_cena;
    logic [9:0]  rf_aa;
    logic [7:0]  rf_qa = '0;
    logic        rf_cenb;
    logic [9:0]  rf_ab;
    logic [7:0]  rf_db;
    logic [2:0]  rf_emaa;
    logic [2:0]  rf_emab;
    logic        rf_ret1n;
    logic        rf_colldisn;

    rf_2p_fifo_ctrl #(
        .AW    (10),
        .DW    (8),
        .EMA_A (3'b010),
        .EMA_B (3'b010)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .count       (count),
        .rf_cena     (rf_cena),
        .rf_aa       (rf_aa),
        .rf_qa       (rf_qa),
        .rf_cenb     (rf_cenb),
        .rf_ab       (rf_ab),
        .rf_db       (rf_db),
        .rf_emaa     (rf_emaa),
        .rf_emab     (rf_emab),
        .rf_ret1n    (rf_ret1n),
        .rf_colldisn (rf_colldisn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        int unsigned acc;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  mem [0:DEPTH-1];
    int unsigned edge_n = 0;
    bit          init_m = 1'b0;
    int unsigned wr_addr_m = 0;
    int unsigned rd_addr_m = 0;
    int unsigned next_word = 0;

    bit          s_push = 1'b0;
    bit          s_pop = 1'b0;
    bit          s_flush = 1'b0;
    bit          s_cena = 1'b1;
    bit          s_cenb = 1'b1;
    logic [9:0]  s_aa = '0;
    logic [9:0]  s_ab = '0;
    logic [7:0]  s_db = '0;

    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", name, act, exp, $time);
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        bit exp_v;
        if (!rst_n) begin
            q.delete();
            init_m    = 1'b0;
            wr_addr_m = 0;
            rd_addr_m = 0;
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_cena", rf_cena, 1);
            chk("rst_cenb", rf_cenb, 1);
            chk("rst_count", count, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_aa", rf_aa, 0);
            chk("rst_ab", rf_ab, 0);
            s_push = 1'b0; s_pop = 1'b0; s_flush = 1'b0; s_cena = 1'b1; s_cenb = 1'b1;
        end else begin
            chk("count", count, q.size());
            exp_v = 1'b0;
            if (q.size() > 0) exp_v = (edge_n - q[0].acc) >= 3;
            chk("rd_valid", rd_valid, exp_v);
            if (exp_v) chk("rd_data", rd_data, q[0].d);
            if (!init_m || flush) chk("wr_ready_off", wr_ready, 0);
            else if (q.size() < DEPTH) chk("wr_ready_on", wr_ready, 1);
            else if (q.size() >= CAP) chk("wr_ready_full", wr_ready, 0);
            chk("cenb", rf_cenb, !(wr_valid && wr_ready));
            if (flush) chk("cena_flush", rf_cena, 1);
            if (!rf_cenb) begin
                chk("ab", rf_ab, wr_addr_m % DEPTH);
                chk("db", rf_db, wr_data);
            end
            if (!rf_cena) chk("aa", rf_aa, rd_addr_m % DEPTH);
            if (!rf_cena && !rf_cenb) chk("collide", rf_aa == rf_ab, 0);
            s_push  = wr_valid && wr_ready;
            s_pop   = rd_valid && rd_ready;
            s_flush = flush;
            s_cena  = rf_cena;
            s_cenb  = rf_cenb;
            s_aa    = rf_aa;
            s_ab    = rf_ab;
            s_db    = rf_db;
        end
    end

    // Macro model and FIFO model update at the rising edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (!s_cena) rf_qa <= mem[s_aa];
            if (!s_cenb) mem[s_ab] = s_db;
            if (s_flush) begin
                q.delete();
                wr_addr_m = 0;
                rd_addr_m = 0;
            end else begin
                if (s_pop && q.size() > 0) void'(q.pop_front());
                if (s_push) begin
                    q.push_back('{d: s_db, acc: edge_n});
                    wr_addr_m++;
                end
                if (!s_cena) rd_addr_m++;
            end
            init_m = 1'b1;
        end
        edge_n++;
    end

    task automatic run(input int unsigned n_words, input int unsigned wr_pct,
                       input int unsigned rd_pct, input int unsigned max_cycles,
                       input bit rand_data, input bit wait_drain,
                       output int unsigned accepted, output int unsigned popped);
        bit holding;
        bit hs_push;
        bit hs_pop;
        accepted = 0;
        popped   = 0;
        holding  = 1'b0;
        for (int unsigned c = 0; c < max_cycles; c++) begin
            if (accepted < n_words && (holding || ($urandom_range(99) < wr_pct))) begin
                if (!holding) wr_data = rand_data ? 8'($urandom) : next_word[7:0];
                wr_valid = 1'b1;
                holding  = 1'b1;
            end else begin
                wr_valid = 1'b0;
            end
            rd_ready = ($urandom_range(99) < rd_pct);
            @(negedge clk); #1;
            hs_push = s_push;
            hs_pop  = s_pop;
            @(posedge clk); #1;
            if (hs_push) begin
                accepted++;
                next_word++;
                holding = 1'b0;
            end
            if (hs_pop) popped++;
            if (wait_drain && accepted == n_words && q.size() == 0) break;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned acc;
        int unsigned pop_n;

        // Reset with wr_valid held high.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("lit_rst_wr_ready", wr_ready, 0);
        chk("lit_rst_cenb", rf_cenb, 1);
        chk("lit_rst_cena", rf_cena, 1);
        chk("lit_rst_count", count, 0);
        chk("lit_rst_rd_valid", rd_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("lit_pre_init_wr_ready", wr_ready, 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk); #1;
        chk("lit_post_init_wr_ready", wr_ready, 1);
        chk("emaa", rf_emaa, 3'b010);
        chk("emab", rf_emab, 3'b010);
        chk("ret1n", rf_ret1n, 1);
        chk("colldisn", rf_colldisn, 1);

        // Single word, first-word latency.
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk); #1;
        chk("lit_c1_cena", rf_cena, 0);
        chk("lit_c1_aa", rf_aa, 0);
        chk("lit_c1_rd_valid", rd_valid, 0);
        @(negedge clk); #1;
        chk("lit_c2_cena", rf_cena, 1);
        chk("lit_c2_rd_valid", rd_valid, 0);
        @(negedge clk); #1;
        chk("lit_c3_rd_valid", rd_valid, 1);
        chk("lit_c3_rd_data", rd_data, 8'hA5);
        chk("lit_c3_count", count, 1);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        @(negedge clk); #1;
        chk("lit_single_drained", count, 0);
        @(posedge clk); #1;

        // Fill to capacity, then drain without gaps.
        next_word = 0;
        run(1030, 100, 0, 1100, 1'b0, 1'b0, acc, pop_n);
        chk("fill_accepted", acc, 1026);
        @(negedge clk); #1;
        chk("lit_fill_count", count, 1026);
        chk("lit_fill_wr_ready", wr_ready, 0);
        @(posedge clk); #1;
        run(0, 0, 100, 1026, 1'b0, 1'b0, acc, pop_n);
        chk("drain_no_gaps", pop_n, 1026);
        @(negedge clk); #1;
        chk("lit_drain_count", count, 0);
        @(posedge clk); #1;

        // Back-to-back streaming across pointer wrap.
        run(3000, 100, 100, 3003, 1'b1, 1'b0, acc, pop_n);
        chk("stream_accepted", acc, 3000);
        chk("stream_popped", pop_n, 3000);

        // Random backpressure.
        run(500, 80, 50, 5000, 1'b1, 1'b1, acc, pop_n);
        chk("bp_accepted", acc, 500);
        chk("bp_popped", pop_n, 500);
        @(negedge clk); #1;
        chk("bp_count", count, 0);
        @(posedge clk); #1;

        // Writer faster than reader: runs against the full boundary.
        run(1500, 90, 30, 9000, 1'b1, 1'b1, acc, pop_n);
        chk("heavy_accepted", acc, 1500);
        chk("heavy_popped", pop_n, 1500);

        // Flush with a word in flight and seven entries held.
        run(8, 100, 0, 8, 1'b1, 1'b0, acc, pop_n);
        chk("flush_setup", acc, 8);
        run(0, 0, 0, 6, 1'b0, 1'b0, acc, pop_n);
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        flush    = 1'b1;
        @(negedge clk); #1;
        chk("lit_flush_cycle_count", count, 7);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk); #1;
        chk("lit_flush_count", count, 0);
        chk("lit_flush_rd_valid", rd_valid, 0);
        @(posedge clk); #1;
        run(0, 0, 100, 6, 1'b0, 1'b0, acc, pop_n);
        chk("flush_no_ghost", pop_n, 0);
        run(3, 100, 100, 40, 1'b1, 1'b1, acc, pop_n);
        chk("flush_restart", pop_n, 3);

        // Same scenario, cleared by asynchronous reset instead.
        run(8, 100, 0, 8, 1'b1, 1'b0, acc, pop_n);
        run(0, 0, 0, 6, 1'b0, 1'b0, acc, pop_n);
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("lit_async_count", count, 0);
        chk("lit_async_rd_valid", rd_valid, 0);
        chk("lit_async_wr_ready", wr_ready, 0);
        chk("lit_async_cena", rf_cena, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("lit_rerst_wr_ready", wr_ready, 0);
        @(posedge clk); #1;
        run(0, 0, 100, 6, 1'b0, 1'b0, acc, pop_n);
        chk("reset_no_ghost", pop_n, 0);
        run(20, 70, 60, 200, 1'b1, 1'b1, acc, pop_n);
        chk("reset_restart", pop_n, 20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_rf_2p_fifo_ctrl

// File: doc/rf_2p_fifo_ctrl.md
# rf_2p_fifo_ctrl

Show-ahead FIFO controller for the 1024x8 synchronous two-port register file (port A read, port B write). It converts a valid/ready write stream and a valid/ready read stream into macro pin activity (CENA/AA, CENB/AB/DB) and hides the macro's one-cycle read latency with a 2-entry output buffer. The controller ties off the static macro pins (EMA, RET1N, COLLDISN) and sits between pixel-line producers/consumers and the `rf_2p_hde_rtl_top` instance.

## Interface
- `AW`, 10: macro address width; depth = 2**AW.
- `DW`, 8: data width.
- `EMA_A`, 3'b010: value driven on `rf_emaa`.
- `EMA_B`, 3'b010: value driven on `rf_emab`.
- `clk`  in  1  single clock, shared with CLKA/CLKB of the macro.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all contents.
- `wr_valid` / `wr_ready` / `wr_data`  in / out / in  1/1/DW  write stream.
- `rd_valid` / `rd_ready` / `rd_data`  out / in / out  1/1/DW  read stream (show-ahead).
- `count`  out  AW+1  total entries held (RAM + in-flight + buffer), max 2**AW+2.
- `rf_cena`, `rf_aa`  out  1, AW  macro read enable (active low), read address.
- `rf_qa`  in  DW  macro read data.
- `rf_cenb`, `rf_ab`, `rf_db`  out  1, AW, DW  macro write enable (active low), write address, write data.
- `rf_emaa`, `rf_emab`  out  3  constants `EMA_A`/`EMA_B`.
- `rf_ret1n`, `rf_colldisn`  out  1  tied to 1.

## Operation
- State: `wr_ptr`, `rd_ptr` (AW bits, natural wrap at 2**AW); `ram_cnt` (AW+1 bits, entries in RAM not yet read-issued); `inflight` (1 bit); output buffer `out`/`skid` (valid + data each).
- Write: `push = wr_valid & wr_ready`. `wr_ready = init_done & (ram_cnt < 2**AW)`, computed from registered state only; there is no combinational path from `rd_ready`. `rf_cenb = ~push`, `rf_ab = wr_ptr`, `rf_db = wr_data`. On push, `wr_ptr` increments.
- Read issue: `pop = rd_valid & rd_ready`. `buf = inflight + out.v + skid.v`. Issue when `ram_cnt != 0` and (`buf < 2`, or `buf == 2` and `pop`).
  - `rf_cena = ~issue`, `rf_aa = rd_ptr`.
  - On issue, `rd_ptr` increments and `inflight` is set for the next cycle.
- Return: when `inflight` is set, `rf_qa` is captured into `out` if `out` is empty or popping, otherwise into `skid`. On pop, `skid` moves to `out`.
- `rd_valid = out.v`, `rd_data = out.d`.
- `ram_cnt` changes by +push − issue. `count` changes by +push − pop.
- Collision: never occurs. `wr_ptr == rd_ptr` with both enables active requires `ram_cnt == 0` (no issue) or `ram_cnt == 2**AW` (no push), so `COLLDISN` stays 1.
- `flush`:
  - Zeroes pointers, counters, `inflight`, `out.v`, `skid.v`. Data returning in-flight is discarded.
  - Has priority over push, pop and issue in the same cycle: `rf_cena = rf_cenb = 1` and `wr_ready = 0` during the flush cycle.
- Reset (async assert, value held until the first rising edge after release):
  - All state cleared; `init_done = 0`, so `wr_ready = 0`.
  - `rd_valid = 0`, `count = 0`, `rd_data = 0`, `rf_cena = rf_cenb = 1`, `rf_aa = rf_ab = 0`.
  - `init_done` is set at the first edge after release.
- Reset mid-operation: all contents are lost; no macro access is issued while `rst_n = 0`.

## Timing
- Write accepted at edge E0 → `rf_cena` low in cycle 1 → macro reads at E1 → `rf_qa` valid in cycle 2, captured at E2 → `rd_valid = 1` in cycle 3. First-word latency is 3 cycles.
- Sustained throughput is 1 word/cycle in each direction when `rd_ready` is held high.
- Capacity is 2**AW + 2 entries. `wr_ready` drops the cycle after `ram_cnt` reaches 2**AW. It reasserts the cycle after the next issue.
- Simultaneous push and pop keep `count` constant.
- A push and an issue to different addresses in the same cycle are legal.
- `rd_ready` may toggle arbitrarily. `rd_data` holds while `rd_valid & ~rd_ready`.

## Structure
- Package `rf_2p_pkg`: `RF_AW = 10`, `RF_DW = 8`, `RF_DEPTH = 1024`, `RF_EMA_DEFAULT = 3'b010`. The package is shared with future controllers for this macro.
- Sub-module `rf_2p_fifo_outbuf`: 2-entry out/skid buffer with inputs `in_valid`, `in_data`, `pop`. It reports an occupancy of 0..2 to the issue logic.
- Top-level logic: pointers, counters, issue/push decode, flush/reset.

## Test plan
- Reset: hold `rst_n = 0` with `wr_valid = 1`.
  - Required: `wr_ready = 0`, `rf_cenb = 1`, `rf_cena = 1`, `count = 0`, `rd_valid = 0`.
  - First edge after release: `wr_ready = 1`.
- Single word: push 0xA5 with `rd_ready = 0`.
  - Required: `rf_cena` low exactly 1 cycle later with `rf_aa = 0`, `rd_valid = 1` 3 cycles after acceptance, `rd_data = 0xA5`, `count = 1`.
- Fill: push 1030 words 0..1029 (mod 256) with `rd_ready = 0`.
  - Required: exactly 1026 accepted, `count = 1026`, `wr_ready = 0`.
  - Then drain: the read sequence is 0..1025 in order with no gaps.
- Streaming and wrap: push and pop 3000 words back-to-back.
  - Required: after first-word latency, one `rd_valid & rd_ready` per cycle, pointers wrap past 1023, data in order, `rf_cena` and `rf_cenb` never both low at the same address.
- Backpressure: random `rd_ready` (50%) while streaming 500 words.
  - Required: no loss or duplication, `rd_data` stable while stalled, `count` equals pushed minus popped.
- Flush and mid-run reset: assert `flush` with `inflight = 1` and `count = 7`.
  - Required: next cycle `count = 0`, `rd_valid = 0`, and the in-flight word never appears.
  - Repeat with `rst_n` asserted: same result, asynchronously.
